fp_pack_round: RTL and testbench

Parametrised final stage of the MAC pipeline. It takes the normalised sum, the biased exponent and the sign. It then performs IEEE-754 rounding (four modes), subnormal denormalisation, overflow saturation and zero handling, and registers the packed result behind a valid/ready handshake. It also accumulates sticky exception flags. It sits after normalisation and drives the MAC result bus; defaults give FP16.

---
 rtl/fp_pack_round.sv | 130 +++++++++++++
 tb/tb_fp_pack_round.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_pack_round.sv
// Final MAC stage: rounds the normalised sum (four IEEE modes), handles subnormals,
// overflow and zero, and registers the packed result behind a valid/ready handshake.
module fp_pack_round #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+1:0]       exp_final,
  input  logic                   sign,
  input  logic [MAN_W+3:0]       norm_sum,
  input  logic [1:0]             rnd_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out,
  output logic [2:0]             flags,
  input  logic                   clr_flags
);

  localparam int SUM_W = MAN_W + 4;
  localparam int EW    = EXP_W + 3;
  localparam int SH_W  = $clog2(SUM_W + 1);
  localparam logic signed [EW-1:0] EMAX_S  = EW'(2**EXP_W - 1);
  localparam logic signed [EW-1:0] SUM_W_S = EW'(SUM_W);
  localparam logic signed [EW-1:0] ONE_S   = EW'(1);

  localparam logic [1:0] RNE = 2'b00;
  localparam logic [1:0] RTZ = 2'b01;
  localparam logic [1:0] RDN = 2'b10;
  localparam logic [1:0] RUP = 2'b11;

  logic                   accept;
  logic                   zero;
  logic                   subn;
  logic signed [EW-1:0]   exp_ext;
  logic signed [EW-1:0]   sh_full;
  logic signed [EW-1:0]   exp_rnd;
  logic [SH_W-1:0]        sh;
  logic [SUM_W-1:0]       shifted;
  logic [SUM_W-1:0]       lost_bits;
  logic [SUM_W-1:0]       m;
  logic                   lsb;
  logic                   g;
  logic                   rs;
  logic                   inexact;
  logic                   inc;
  logic [MAN_W+1:0]       r;
  logic                   carry;
  logic                   overflow;
  logic                   round_away;
  logic [EXP_W+MAN_W:0]   res;
  logic [2:0]             beat_flags;

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  assign zero    = (norm_sum == '0);
  assign exp_ext = {exp_final[EXP_W+1], exp_final};
  assign subn    = exp_final[EXP_W+1] | (exp_final == '0);
  assign sh_full = ONE_S - exp_ext;
  assign sh      = (sh_full > SUM_W_S) ? SH_W'(SUM_W) : sh_full[SH_W-1:0];

  // Left-shifting by (width - sh) leaves exactly the bits that the right shift drops.
  assign shifted   = norm_sum >> sh;
  assign lost_bits = norm_sum << (SH_W'(SUM_W) - sh);
  assign m         = subn ? {shifted[SUM_W-1:1], shifted[0] | (|lost_bits)} : norm_sum;

  assign lsb     = m[3];
  assign g       = m[2];
  assign rs      = m[1] | m[0];
  assign inexact = g | rs;

  always_comb begin
    inc = 1'b0;
    case (rnd_mode)
      RNE:     inc = g & (rs | lsb);
      RTZ:     inc = 1'b0;
      RDN:     inc = sign & inexact;
      RUP:     inc = ~sign & inexact;
      default: inc = 1'b0;
    endcase
  end

  assign r          = {1'b0, m[SUM_W-1:3]} + (MAN_W+2)'(inc);
  assign carry      = r[MAN_W+1];
  assign exp_rnd    = exp_ext + $signed({{(EW-1){1'b0}}, carry});
  assign overflow   = ~zero & ~subn & (exp_rnd >= EMAX_S);
  assign round_away = (rnd_mode == RNE) | ((rnd_mode == RUP) & ~sign) | ((rnd_mode == RDN) & sign);

  always_comb begin
    res        = {sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
    beat_flags = 3'b000;
    if (!zero) begin
      if (overflow) begin
        res = round_away ? {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                         : {sign, {{(EXP_W-1){1'b1}}, 1'b0}, {MAN_W{1'b1}}};
      end else if (subn) begin
        // A carry into r[MAN_W] lands on the smallest normal with no extra handling.
        res = {sign, {{(EXP_W-1){1'b0}}, r[MAN_W]}, r[MAN_W-1:0]};
      end else begin
        res = {sign, exp_rnd[EXP_W-1:0], carry ? {MAN_W{1'b0}} : r[MAN_W-1:0]};
      end
      beat_flags = {overflow, subn & inexact, inexact | overflow};
    end
  end

  // Flags of an accepted beat are applied after a coincident clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out       <= '0;
      out_valid <= 1'b0;
      flags     <= 3'b000;
    end else begin
      if (accept) begin
        out       <= res;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (clr_flags) begin
        flags <= accept ? beat_flags : 3'b000;
      end else if (accept) begin
        flags <= flags | beat_flags;
      end
    end
  end

endmodule

// File: tb/tb_fp_pack_round.sv
// Bench for fp_pack_round (FP16): directed literal cases, handshake/reset checks and a
// randomized run compared every cycle against an exact-arithmetic rounding model.
module tb_fp_pack_round;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  exp_final;
  logic        sign;
  logic [13:0] norm_sum;
  logic [1:0]  rnd_mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic [2:0]  flags;
  logic        clr_flags;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int n_del    = 0;

  logic        m_valid;
  logic [15:0] m_out;
  logic [2:0]  m_flags;

  fp_pack_round #(.EXP_W(5), .MAN_W(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .exp_final(exp_final), .sign(sign), .norm_sum(norm_sum), .rnd_mode(rnd_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .flags(flags),
    .clr_flags(clr_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Exact value is norm_sum * 2^(e-BIAS-13); divide by the target grid step and round.
  function automatic void refPack(input int e, input bit s, input int ns, input int mode,
                                  output logic [15:0] res, output logic [2:0] fl);
    longint k, rem, p, mag;
    int     d, e_eff, big_e, field_e;
    bit     inexact, up, ovf, away;
    if (ns == 0) begin
      res = {s, 15'h0};
      fl  = 3'b000;
      return;
    end
    e_eff = (e >= 1) ? e : 1;
    d     = 3 + e_eff - e;
    if (d > 40) begin
      p   = longint'(1) << 40;
      k   = 0;
      rem = ns;
    end else begin
      p   = longint'(1) << d;
      k   = ns / p;
      rem = ns % p;
    end
    inexact = (rem != 0);
    case (mode)
      0:       up = (2 * rem > p) || ((2 * rem == p) && (k % 2 == 1));
      1:       up = 1'b0;
      2:       up = s && inexact;
      default: up = !s && inexact;
    endcase
    mag   = k + longint'(up);
    big_e = e_eff;
    if (mag >= 2048) begin
      mag   = mag / 2;
      big_e = big_e + 1;
    end
    if (mag >= 1024) begin
      field_e = big_e;
      mag     = mag - 1024;
    end else begin
      field_e = 0;
    end
    ovf = (field_e >= 31);
    if (ovf) begin
      away = (mode == 0) || (mode == 3 && !s) || (mode == 2 && s);
      res  = away ? {s, 5'h1F, 10'h000} : {s, 5'h1E, 10'h3FF};
    end else begin
      res = {s, 5'(field_e), 10'(mag)};
    end
    fl = {ovf, (e <= 0) && inexact, inexact || ovf};
  endfunction

  // Reference state advances on the same edge the DUT samples.
  always @(posedge clk or negedge rst) begin
    logic [15:0] r_res;
    logic [2:0]  r_fl;
    bit          acc;
    if (!rst) begin
      m_valid = 1'b0;
      m_out   = 16'h0;
      m_flags = 3'b000;
    end else begin
      acc = in_valid && (!m_valid || out_ready);
      refPack(int'($signed(exp_final)), sign, int'(norm_sum), int'(rnd_mode), r_res, r_fl);
      if (clr_flags) m_flags = 3'b000;
      if (acc) begin
        m_out   = r_res;
        m_valid = 1'b1;
        m_flags = m_flags | r_fl;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      if (in_valid && in_ready) n_acc++;
      if (out_valid && out_ready) n_del++;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      checkOutput("in_ready", in_ready, !m_valid || out_ready);
      checkOutput("out_valid", out_valid, m_valid);
      if (m_valid) checkOutput("out", out, m_out);
      checkOutput("flags", flags, m_flags);
    end
  end

  task automatic applyStimulus(input logic [6:0] e, input logic s, input logic [13:0] ns,
                               input logic [1:0] mode, input logic v, input logic ordy, input logic clr);
    @(posedge clk);
    #2;
    exp_final = e;
    sign      = s;
    norm_sum  = ns;
    rnd_mode  = mode;
    in_valid  = v;
    out_ready = ordy;
    clr_flags = clr;
  endtask

  task automatic directedBeat(input string name, input logic [6:0] e, input logic s, input logic [13:0] ns,
                              input logic [1:0] mode, input logic clr,
                              input logic [15:0] exp_out, input logic [2:0] exp_fl);
    applyStimulus(e, s, ns, mode, 1'b1, 1'b1, clr);
    applyStimulus(7'h0, 1'b0, 14'h0, 2'b00, 1'b0, 1'b1, 1'b0);
    checkOutput(name, out, exp_out);
    checkOutput({name, "_flags"}, flags, exp_fl);
  endtask

  task automatic randomBeat(input logic v, input logic ordy, input logic clr);
    logic [6:0]  e;
    logic [13:0] ns;
    if ($urandom_range(0, 3) == 0) e = 7'($urandom_range(0, 127));
    else e = 7'(int'($urandom_range(0, 45)) - 12);
    if ($urandom_range(0, 15) == 0) ns = 14'h0;
    else ns = {1'b1, 13'($urandom_range(0, 8191))};
    applyStimulus(e, 1'($urandom_range(0, 1)), ns, 2'($urandom_range(0, 3)), v, ordy, clr);
  endtask

  initial begin
    logic [15:0] held;
    logic [15:0] pin_res;
    logic [2:0]  pin_fl;

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_flags = 1'b0;
    exp_final = '0; sign = 1'b0; norm_sum = '0; rnd_mode = 2'b00;

    refPack(15, 1'b0, 14'h3FFF, 0, pin_res, pin_fl);
    checkOutput("model_carry", {pin_fl, pin_res}, {3'b001, 16'h4000});
    refPack(-20, 1'b0, 14'h2001, 3, pin_res, pin_fl);
    checkOutput("model_subn", {pin_fl, pin_res}, {3'b011, 16'h0001});

    repeat (2) @(posedge clk);
    #2;
    checkOutput("rst_out", out, 16'h0);
    checkOutput("rst_valid", out_valid, 1'b0);
    checkOutput("rst_flags", flags, 3'b000);
    checkOutput("rst_ready", in_ready, 1'b1);
    rst = 1'b1;

    directedBeat("exact",     7'd15, 1'b0, 14'h2000, 2'b00, 1'b1, 16'h3C00, 3'b000);
    directedBeat("carry_rne", 7'd15, 1'b0, 14'h3FFF, 2'b00, 1'b1, 16'h4000, 3'b001);
    directedBeat("carry_rtz", 7'd15, 1'b0, 14'h3FFF, 2'b01, 1'b1, 16'h3FFF, 3'b001);
    directedBeat("ovf_rne",   7'd31, 1'b0, 14'h2000, 2'b00, 1'b1, 16'h7C00, 3'b101);
    directedBeat("ovf_rtz",   7'd31, 1'b0, 14'h2000, 2'b01, 1'b1, 16'h7BFF, 3'b101);
    directedBeat("ovf_rdn_p", 7'd31, 1'b0, 14'h2000, 2'b10, 1'b1, 16'h7BFF, 3'b101);
    directedBeat("ovf_rdn_n", 7'd31, 1'b1, 14'h2000, 2'b10, 1'b1, 16'hFC00, 3'b101);
    directedBeat("subn_exact", 7'd0, 1'b0, 14'h2000, 2'b00, 1'b1, 16'h0200, 3'b000);
    directedBeat("tiny_rup",  7'h6C, 1'b0, 14'h2001, 2'b11, 1'b1, 16'h0001, 3'b011);
    directedBeat("tiny_rtz",  7'h6C, 1'b0, 14'h2001, 2'b01, 1'b1, 16'h0000, 3'b011);
    directedBeat("zero_neg",  7'd0,  1'b1, 14'h0000, 2'b00, 1'b0, 16'h8000, 3'b011);

    applyStimulus(7'h0, 1'b0, 14'h0, 2'b00, 1'b0, 1'b1, 1'b1);
    applyStimulus(7'h0, 1'b0, 14'h0, 2'b00, 1'b0, 1'b1, 1'b0);
    checkOutput("clr_alone", flags, 3'b000);

    n_acc = 0;
    n_del = 0;
    for (int i = 0; i < 4; i++) randomBeat(1'b1, 1'b1, 1'b0);
    randomBeat(1'b1, 1'b0, 1'b0);
    held = out;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2;
      checkOutput("stall_out", out, held);
      checkOutput("stall_ready", in_ready, 1'b0);
      checkOutput("stall_valid", out_valid, 1'b1);
    end
    checkOutput("stall_accepted", n_acc, 4);
    checkOutput("stall_delivered", n_del, 3);

    #1;
    rst = 1'b0;
    #1;
    checkOutput("midrst_valid", out_valid, 1'b0);
    checkOutput("midrst_out", out, 16'h0);
    checkOutput("midrst_flags", flags, 3'b000);
    checkOutput("midrst_ready", in_ready, 1'b1);
    @(posedge clk);
    #2;
    rst = 1'b1;

    for (int i = 0; i < 600; i++) begin
      randomBeat($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end
    applyStimulus(7'h0, 1'b0, 14'h0, 2'b00, 1'b0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #2;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
